wm_plant: RTL and testbench
===========================

# wm_plant

Synthesizable plant model of the washing-machine hardware, the sensor side of the controller interface. It consumes the controller's actuator commands (door lock, motor, fill valve, drain pump, phase flags) and produces the sensor feedback the controller waits on (fill, detergent, timeout, drained, spin_timeout) using internal water-level and phase timers. It replaces hand-driven sensor stimulus in closed-loop benches and FPGA demos, and flags unsafe actuator combinations.

## Interface

Parameters:
- FILL_CYCLES, 8: cycles of fill_on to reach full level
- DET_CYCLES, 4: cycles of soapWash at full level to dose detergent
- WASH_CYCLES, 16: motor cycles at full level until timeout
- SPIN_CYCLES, 12: motor cycles with drain_on at empty level until spin_timeout
- LEVEL_W, $clog2(FILL_CYCLES+1): level counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- door_lock  in  1  door locked by controller
- motor_on  in  1  drum motor command
- fill_on  in  1  inlet valve command
- drain_on  in  1  drain pump command
- soapWash  in  1  controller in soap phase
- waterWash  in  1  controller in rinse phase
- fill  out  1  tub full
- detergent  out  1  detergent dose complete
- timeout  out  1  wash time elapsed
- drained  out  1  tub empty while pumping
- spin_timeout  out  1  spin time elapsed
- fault  out  1  sticky safety fault
- level  out  LEVEL_W  current water level

## Operation

- All outputs registered; all reset to 0 (level=0).
- Level: +1 per cycle when fill_on & !drain_on & level<FILL_CYCLES; -1 when drain_on & !fill_on & level>0; hold otherwise (both on = hold). Saturates at 0 and FILL_CYCLES.
- fill = (level==FILL_CYCLES).
- Dose counter: +1 when soapWash & level==FILL_CYCLES, saturates at DET_CYCLES; detergent = (dose==DET_CYCLES). Cleared when level reaches 0.
- Wash counter: +1 when motor_on & !drain_on & level==FILL_CYCLES, saturates at WASH_CYCLES; timeout = (wash==WASH_CYCLES). Cleared when level reaches 0 (held through draining so controller can observe it).
- drained = (level==0) & drain_on.
- Spin counter: +1 when motor_on & drain_on & level==0, saturates at SPIN_CYCLES; spin_timeout = (spin==SPIN_CYCLES). Cleared when motor_on==0.
- waterWash is informational: it enables wash counting identically to soapWash-phase motor operation; no dosing.
- Fault: set when door_lock==0 while any of motor_on, fill_on, drain_on is 1. Sticky until reset. While fault=1 all counters freeze; sensor outputs hold last value.

## Timing

- Each output is decoded from the next-state counter values, so an output changes on the same edge the counter reaches its threshold. Example: fill_on held from edge 0 gives level==8 and fill=1 after edge 8.
- drained updates one edge after drain_on changes (registered), even if level was already 0.
- Fault asserts on the edge sampling the illegal combination; the counter update of that same edge is suppressed.
- Reset mid-operation: next edge returns all counters and outputs to 0, fault cleared; inputs during reset ignored.
- Simultaneous level reaching 0 and dose/wash clear: clears take effect on the same edge.

## Structure

- wm_pkg: default cycle constants (FILL_CYCLES etc.) shared with the controller bench; no typedefs needed.
- One sub-module natural: wm_sat_counter (parameter MAX, width; inc, dec, clr, hold inputs; value and at_max outputs), instantiated four times (level, dose, wash, spin).
- Top holds fault flop, output registers, enable decode.

## Test plan

- Reset, door_lock=1, fill_on=1 for 10 cycles -> level counts 1..8, fill=1 after 8th edge, level stays 8.
- From full: soapWash=1 for 4 cycles -> detergent=1 after 4th edge; motor_on=1 for 16 cycles -> timeout=1 after 16th edge, remains 1.
- From full with timeout=1: drain_on=1 -> level decrements to 0 over 8 edges; drained=1 one edge after level==0; detergent and timeout cleared at that edge.
- At empty with drain_on=1, motor_on=1 for 12 cycles -> spin_timeout=1 after 12th edge; drop motor_on -> spin_timeout=0 next edge.
- door_lock=0 with fill_on=1 at level 3 -> fault=1 next edge, level frozen at 3 for any further stimulus; reset=1 one cycle -> fault=0, level=0.
- fill_on=1 and drain_on=1 together at level 5 -> level holds 5, fill=0, drained=0.

Source files
------------

// File: rtl/wm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wm_pkg : default washing-machine plant cycle constants               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package wm_pkg;
  localparam int DEF_FILL_CYCLES = 8;
  localparam int DEF_DET_CYCLES  = 4;
  localparam int DEF_WASH_CYCLES = 16;
  localparam int DEF_SPIN_CYCLES = 12;
endpackage
`default_nettype wire

// File: rtl/wm_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wm_sat_counter : up/down counter saturating at 0 and MAX             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wm_sat_counter #(
  parameter int MAX   = 8,
  parameter int WIDTH = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  input  logic             hold,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] value_next,
  output logic             at_max
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  // hold beats clear beats counting
  always_comb begin
    value_next = value;
    if (hold) begin
      value_next = value;
    end else if (clr) begin
      value_next = '0;
    end else if (inc && (value != MAX_V)) begin
      value_next = value + 1'b1;
    end else if (dec && (value != '0)) begin
      value_next = value - 1'b1;
    end
  end

  // at_max is decoded from the next value so it flips on the same edge as value
  always_ff @(posedge clk) begin
    if (reset) begin
      value  <= '0;
      at_max <= 1'b0;
    end else begin
      value  <= value_next;
      at_max <= (value_next == MAX_V);
    end
  end
endmodule
`default_nettype wire

// File: rtl/wm_plant.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wm_plant : washing-machine plant model producing sensor feedback     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wm_plant
  import wm_pkg::*;
#(
  parameter int FILL_CYCLES = DEF_FILL_CYCLES,
  parameter int DET_CYCLES  = DEF_DET_CYCLES,
  parameter int WASH_CYCLES = DEF_WASH_CYCLES,
  parameter int SPIN_CYCLES = DEF_SPIN_CYCLES,
  parameter int LEVEL_W     = $clog2(FILL_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               door_lock,
  input  logic               motor_on,
  input  logic               fill_on,
  input  logic               drain_on,
  input  logic               soapWash,
  input  logic               waterWash,
  output logic               fill,
  output logic               detergent,
  output logic               timeout,
  output logic               drained,
  output logic               spin_timeout,
  output logic               fault,
  output logic [LEVEL_W-1:0] level
);
  localparam int DOSE_W = $clog2(DET_CYCLES + 1);
  localparam int WASH_W = $clog2(WASH_CYCLES + 1);
  localparam int SPIN_W = $clog2(SPIN_CYCLES + 1);

  logic               fault_next;
  logic               level_empty;
  logic               level_next_empty;
  logic [LEVEL_W-1:0] level_next;
  logic [DOSE_W-1:0]  dose_value;
  logic [DOSE_W-1:0]  dose_next;
  logic [WASH_W-1:0]  wash_value;
  logic [WASH_W-1:0]  wash_next;
  logic [SPIN_W-1:0]  spin_value;
  logic [SPIN_W-1:0]  spin_next;
  // rinse phase has no effect of its own: wash counting ignores the phase flags
  logic               unused_phase;

  assign unused_phase     = waterWash;
  assign fault_next       = fault | (~door_lock & (motor_on | fill_on | drain_on));
  assign level_empty      = (level == '0);
  assign level_next_empty = (level_next == '0);

  wm_sat_counter #(.MAX(FILL_CYCLES), .WIDTH(LEVEL_W)) u_level (
    .clk        (clk),
    .reset      (reset),
    .inc        (fill_on & ~drain_on),
    .dec        (drain_on & ~fill_on),
    .clr        (1'b0),
    .hold       (fault_next),
    .value      (level),
    .value_next (level_next),
    .at_max     (fill)
  );

  // fill is the registered "level == FILL_CYCLES" flag, used as the full condition
  wm_sat_counter #(.MAX(DET_CYCLES), .WIDTH(DOSE_W)) u_dose (
    .clk        (clk),
    .reset      (reset),
    .inc        (soapWash & fill),
    .dec        (1'b0),
    .clr        (level_next_empty),
    .hold       (fault_next),
    .value      (dose_value),
    .value_next (dose_next),
    .at_max     (detergent)
  );

  wm_sat_counter #(.MAX(WASH_CYCLES), .WIDTH(WASH_W)) u_wash (
    .clk        (clk),
    .reset      (reset),
    .inc        (motor_on & ~drain_on & fill),
    .dec        (1'b0),
    .clr        (level_next_empty),
    .hold       (fault_next),
    .value      (wash_value),
    .value_next (wash_next),
    .at_max     (timeout)
  );

  wm_sat_counter #(.MAX(SPIN_CYCLES), .WIDTH(SPIN_W)) u_spin (
    .clk        (clk),
    .reset      (reset),
    .inc        (motor_on & drain_on & level_empty),
    .dec        (1'b0),
    .clr        (~motor_on),
    .hold       (fault_next),
    .value      (spin_value),
    .value_next (spin_next),
    .at_max     (spin_timeout)
  );

  // drained looks at the current level, so it trails the level reaching zero by one edge
  always_ff @(posedge clk) begin
    if (reset) begin
      fault   <= 1'b0;
      drained <= 1'b0;
    end else begin
      fault <= fault_next;
      if (!fault_next) begin
        drained <= level_empty & drain_on;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_wm_plant.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wm_plant : directed self-checking bench for wm_plant              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_wm_plant;
  logic       clk = 1'b0;
  logic       reset;
  logic       door_lock, motor_on, fill_on, drain_on, soapWash, waterWash;
  logic       fill, detergent, timeout, drained, spin_timeout, fault;
  logic [3:0] level;

  int passes = 0;
  int total  = 0;

  wm_plant dut (
    .clk          (clk),
    .reset        (reset),
    .door_lock    (door_lock),
    .motor_on     (motor_on),
    .fill_on      (fill_on),
    .drain_on     (drain_on),
    .soapWash     (soapWash),
    .waterWash    (waterWash),
    .fill         (fill),
    .detergent    (detergent),
    .timeout      (timeout),
    .drained      (drained),
    .spin_timeout (spin_timeout),
    .fault        (fault),
    .level        (level)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; door_lock = 1'b0; motor_on = 1'b0; fill_on = 1'b0;
    drain_on = 1'b0; soapWash = 1'b0; waterWash = 1'b0;
    tick(1);
    check("rst_level", 32'(level), 0);
    check("rst_outs", {26'd0, fill, detergent, timeout, drained, spin_timeout, fault}, 0);

    // fill from empty
    reset = 1'b0; door_lock = 1'b1; fill_on = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      check("fill_level", 32'(level), (i < 8) ? i : 8);
      check("fill_flag", 32'(fill), (i >= 8) ? 1 : 0);
    end
    fill_on = 1'b0;

    // detergent dosing at full level
    soapWash = 1'b1;
    tick(3);
    check("det_early", 32'(detergent), 0);
    tick(1);
    check("det_done", 32'(detergent), 1);
    soapWash = 1'b0; waterWash = 1'b1;

    // wash timer
    motor_on = 1'b1;
    tick(15);
    check("wash_early", 32'(timeout), 0);
    tick(1);
    check("wash_done", 32'(timeout), 1);
    tick(2);
    check("wash_hold", 32'(timeout), 1);
    motor_on = 1'b0; waterWash = 1'b0;

    // drain to empty
    drain_on = 1'b1;
    tick(1);
    check("drain_fill_low", 32'(fill), 0);
    tick(6);
    check("drain_level1", 32'(level), 1);
    check("drain_to_held", 32'(timeout), 1);
    tick(1);
    check("drain_level0", 32'(level), 0);
    check("drain_to_clr", 32'(timeout), 0);
    check("drain_det_clr", 32'(detergent), 0);
    check("drained_lag", 32'(drained), 0);
    tick(1);
    check("drained_set", 32'(drained), 1);

    // spin at empty
    motor_on = 1'b1;
    tick(11);
    check("spin_early", 32'(spin_timeout), 0);
    tick(1);
    check("spin_done", 32'(spin_timeout), 1);
    motor_on = 1'b0;
    tick(1);
    check("spin_clr", 32'(spin_timeout), 0);
    check("fault_none", 32'(fault), 0);

    // fault freezes the plant
    reset = 1'b1; drain_on = 1'b0;
    tick(1);
    reset = 1'b0; fill_on = 1'b1;
    tick(3);
    check("pre_fault_level", 32'(level), 3);
    door_lock = 1'b0;
    tick(1);
    check("fault_set", 32'(fault), 1);
    check("fault_level", 32'(level), 3);
    door_lock = 1'b1;
    tick(2);
    check("fault_sticky", 32'(fault), 1);
    check("fault_frozen", 32'(level), 3);
    reset = 1'b1;
    tick(1);
    check("fault_rst", 32'(fault), 0);
    check("fault_rst_level", 32'(level), 0);

    // fill and drain together hold level
    reset = 1'b0;
    tick(5);
    check("both_pre", 32'(level), 5);
    drain_on = 1'b1;
    tick(2);
    check("both_level", 32'(level), 5);
    check("both_fill", 32'(fill), 0);
    check("both_drained", 32'(drained), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
`default_nettype wire
